// File: rtl/fetch_stage_if.sv
// Instruction-memory request/return bus between the fetch stage
// and a synchronous instruction memory with one cycle of read latency.
interface fetch_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: PC sequencing, imem requests,
// stall/flush/redirect handling and a one-entry return skid.
module fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    fetch_stage_if.master   imem,
    input  logic            stall_f,
    input  logic            flush_d,
    input  logic            pc_src_e,
    input  logic [XLEN-1:0] pc_target_e,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            valid_d
);

    localparam logic [XLEN-1:0] ALIGN = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] STEP  = XLEN'(4);

    logic [XLEN-1:0] pcf;
    logic [XLEN-1:0] req_pc_q;
    logic            req_valid_q;
    logic [XLEN-1:0] skid_pc;
    logic [31:0]     skid_instr;
    logic            skid_valid;
    logic            issue;
    logic [XLEN-1:0] fetch_addr;

    // A redirect always issues, even under stall; reset blocks issue.
    always_comb begin
        issue      = ~rst & (pc_src_e | ~stall_f);
        fetch_addr = pc_src_e ? (pc_target_e & ALIGN) : pcf;
    end

    assign imem.imem_req  = issue;
    assign imem.imem_addr = fetch_addr;

    // PC register and record of the request whose data returns next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcf         <= RESET_PC;
            req_valid_q <= 1'b0;
            req_pc_q    <= '0;
        end else begin
            req_valid_q <= issue;
            if (issue) begin
                pcf      <= fetch_addr + STEP;
                req_pc_q <= fetch_addr;
            end
        end
    end

    // IF/ID register and skid, in priority order redirect > stall > flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            InstrD     <= NOP_INSTR;
            PCD        <= '0;
            PCPlus4D   <= '0;
            valid_d    <= 1'b0;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else if (pc_src_e) begin
            InstrD     <= NOP_INSTR;
            PCD        <= '0;
            PCPlus4D   <= '0;
            valid_d    <= 1'b0;
            skid_valid <= 1'b0;
        end else if (stall_f) begin
            if (req_valid_q) begin
                skid_valid <= 1'b1;
                skid_pc    <= req_pc_q;
                skid_instr <= imem.imem_rdata;
            end
        end else if (flush_d) begin
            InstrD     <= NOP_INSTR;
            PCD        <= '0;
            PCPlus4D   <= '0;
            valid_d    <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            InstrD     <= skid_instr;
            PCD        <= skid_pc;
            PCPlus4D   <= skid_pc + STEP;
            valid_d    <= 1'b1;
            skid_valid <= 1'b0;
        end else if (req_valid_q) begin
            InstrD   <= imem.imem_rdata;
            PCD      <= req_pc_q;
            PCPlus4D <= req_pc_q + STEP;
            valid_d  <= 1'b1;
        end else begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            valid_d  <= 1'b0;
        end
    end

endmodule
